// File: rtl/line_clock_out_engine.sv
// Clocks one display line of 32-bit words out of a line FIFO toward the SLM.
// Fixed two-cycle latency from FIFO pop to slm_data; stall watchdog aborts a starved line.
module line_clock_out_engine #(
  parameter int WORDS_PER_LINE  = 40,
  parameter int LINES_PER_FRAME = 1280,
  parameter int STALL_LIMIT     = 255
) (
  input  logic        fpga_clk,
  input  logic        reset_all,
  input  logic        start_line,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_rd_data,
  input  logic        clr_err,
  output logic        fifo_rd_en,
  output logic [31:0] slm_data,
  output logic        slm_data_valid,
  output logic        slm_line_start,
  output logic        line_done,
  output logic        frame_done,
  output logic        busy,
  output logic [10:0] line_index,
  output logic        underrun_err
);

  // Handshake: fifo_rd_en is a pop strobe, the FIFO presents the popped word on
  // fifo_rd_data the next cycle; slm_data is meaningful only while slm_data_valid=1
  // and the SLM side has no back-pressure.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0]  WPL        = 8'(WORDS_PER_LINE);
  localparam logic [7:0]  LAST_WORD  = 8'(WORDS_PER_LINE - 1);
  localparam logic [7:0]  STALL_LAST = 8'(STALL_LIMIT - 1);
  localparam logic [10:0] LAST_LINE  = 11'(LINES_PER_FRAME - 1);

  state_t     state;
  logic [7:0] req_cnt;
  logic [7:0] out_cnt;
  logic [7:0] stall_cnt;
  logic       rd_pend;
  logic       aborted;

  logic stalling;
  logic stall_trip;
  logic last_out;

  assign fifo_rd_en = (state == READ) & ~fifo_empty & (req_cnt < WPL);
  assign stalling   = (state == READ) &  fifo_empty & (req_cnt < WPL);
  assign stall_trip = stalling & (stall_cnt == STALL_LAST);
  // An aborted line never reaches its last word, the gate keeps that explicit.
  assign last_out   = rd_pend & (out_cnt == LAST_WORD) & ~aborted;

  always_ff @(posedge fpga_clk or posedge reset_all) begin
    if (reset_all) begin
      state          <= IDLE;
      req_cnt        <= 8'd0;
      out_cnt        <= 8'd0;
      stall_cnt      <= 8'd0;
      rd_pend        <= 1'b0;
      aborted        <= 1'b0;
      slm_data       <= 32'd0;
      slm_data_valid <= 1'b0;
      slm_line_start <= 1'b0;
      line_done      <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
      line_index     <= 11'd0;
      underrun_err   <= 1'b0;
    end else begin
      rd_pend        <= fifo_rd_en;
      slm_data_valid <= rd_pend;
      slm_line_start <= rd_pend & (out_cnt == 8'd0);
      line_done      <= last_out;
      frame_done     <= last_out & (line_index == LAST_LINE);

      if (rd_pend) begin
        slm_data <= fifo_rd_data;
        out_cnt  <= out_cnt + 8'd1;
      end

      if (stall_trip) begin
        underrun_err <= 1'b1;
      end else if (clr_err) begin
        underrun_err <= 1'b0;
      end

      if (line_done) begin
        line_index <= (line_index == LAST_LINE) ? 11'd0 : line_index + 11'd1;
      end

      case (state)
        IDLE: begin
          if (start_line) begin
            state     <= READ;
            busy      <= 1'b1;
            req_cnt   <= 8'd0;
            out_cnt   <= 8'd0;
            stall_cnt <= 8'd0;
            aborted   <= 1'b0;
          end
        end
        READ: begin
          if (fifo_rd_en) begin
            req_cnt   <= req_cnt + 8'd1;
            stall_cnt <= 8'd0;
            if (req_cnt == LAST_WORD) begin
              state <= DRAIN;
            end
          end else if (stalling) begin
            stall_cnt <= stall_cnt + 8'd1;
            if (stall_trip) begin
              aborted <= 1'b1;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Aborted lines leave once the last popped word has reached slm_data.
          if (line_done || (aborted && !rd_pend)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_clock_out_engine.sv
// Directed bench for line_clock_out_engine: a simple FIFO model feeds words,
// a cycle-indexed recorder captures output events, assertions check them.
module tb_line_clock_out_engine;

  logic        fpga_clk = 1'b0;
  logic        reset_all = 1'b1;
  logic        start_line = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_rd_data = 32'd0;
  logic        clr_err = 1'b0;
  logic        fifo_rd_en;
  logic [31:0] slm_data;
  logic        slm_data_valid;
  logic        slm_line_start;
  logic        line_done;
  logic        frame_done;
  logic        busy;
  logic [10:0] line_index;
  logic        underrun_err;

  line_clock_out_engine #(
    .WORDS_PER_LINE(40),
    .LINES_PER_FRAME(4),
    .STALL_LIMIT(255)
  ) dut (
    .fpga_clk(fpga_clk),
    .reset_all(reset_all),
    .start_line(start_line),
    .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .clr_err(clr_err),
    .fifo_rd_en(fifo_rd_en),
    .slm_data(slm_data),
    .slm_data_valid(slm_data_valid),
    .slm_line_start(slm_line_start),
    .line_done(line_done),
    .frame_done(frame_done),
    .busy(busy),
    .line_index(line_index),
    .underrun_err(underrun_err)
  );

  // clock/reset
  always #5 fpga_clk = ~fpga_clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: words popped from the FIFO model, in order
  logic [31:0] exp_q[$];
  logic [31:0] fifo_ptr = 32'd0;

  function automatic logic [31:0] pat(input logic [31:0] p);
    return 32'hA500_0000 ^ (p * 32'h0001_0003);
  endfunction

  always @(posedge fpga_clk or posedge reset_all) begin
    if (reset_all) begin
      exp_q.delete();
    end else if (fifo_rd_en) begin
      fifo_rd_data <= pat(fifo_ptr);
      exp_q.push_back(pat(fifo_ptr));
      fifo_ptr <= fifo_ptr + 32'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // per-line event recorder, cycle t=0 is the start_line cycle
  int t, n_rd, first_rd, last_rd, stall_rd, n_v, first_v, last_v;
  int ls_cyc, n_ls, ld_cyc, n_ld, n_fd, last_busy, first_err, clear_at;

  task automatic clear_rec();
    t = 0; n_rd = 0; first_rd = -1; last_rd = -1; stall_rd = 0;
    n_v = 0; first_v = -1; last_v = -1; ls_cyc = -1; n_ls = 0;
    ld_cyc = -1; n_ld = 0; n_fd = 0; last_busy = -1; first_err = -1; clear_at = -1;
  endtask

  // driver: apply inputs mid-cycle, then sample outputs for that cycle
  task automatic step(input logic st, input logic emp, input logic clr);
    @(negedge fpga_clk);
    start_line = st;
    fifo_empty = emp;
    clr_err    = clr;
    #1;
    if (fifo_rd_en) begin
      n_rd++;
      if (first_rd < 0) first_rd = t;
      last_rd = t;
      if (fifo_empty) stall_rd++;
    end
    if (slm_data_valid) begin
      n_v++;
      if (first_v < 0) first_v = t;
      last_v = t;
      if (exp_q.size() == 0) chk("word_expected", 32'd0, 32'd1);
      else chk("word_order", slm_data, exp_q.pop_front());
    end
    if (slm_line_start) begin n_ls++; ls_cyc = t; end
    if (line_done) begin n_ld++; ld_cyc = t; end
    if (frame_done) n_fd++;
    if (busy) last_busy = t;
    if (underrun_err && first_err < 0) first_err = t;
    if (!underrun_err && first_err >= 0 && clear_at < 0) clear_at = t;
    t++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, 32'({fifo_rd_en, slm_data_valid, slm_line_start, line_done,
                              frame_done, busy, underrun_err}), 32'd0);
    chk({tag, "_data"}, slm_data, 32'd0);
    chk({tag, "_index"}, 32'(line_index), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge fpga_clk);
    #1;
    chk_zero("reset");
    @(negedge fpga_clk);
    reset_all = 1'b0;

    // full line, FIFO never empty
    clear_rec();
    step(1'b1, 1'b0, 1'b0);
    repeat (45) step(1'b0, 1'b0, 1'b0);
    chk("t1_first_rd", 32'(first_rd), 32'd1);
    chk("t1_last_rd", 32'(last_rd), 32'd40);
    chk("t1_n_rd", 32'(n_rd), 32'd40);
    chk("t1_first_valid", 32'(first_v), 32'd3);
    chk("t1_last_valid", 32'(last_v), 32'd42);
    chk("t1_n_valid", 32'(n_v), 32'd40);
    chk("t1_line_start", 32'(ls_cyc), 32'd3);
    chk("t1_n_line_start", 32'(n_ls), 32'd1);
    chk("t1_line_done", 32'(ld_cyc), 32'd42);
    chk("t1_n_frame_done", 32'(n_fd), 32'd0);
    chk("t1_last_busy", 32'(last_busy), 32'd42);
    chk("t1_line_index", 32'(line_index), 32'd1);
    chk("t1_data_hold", slm_data, pat(32'd39));
    chk("t1_valid_low", 32'(slm_data_valid), 32'd0);

    // ten-cycle stall mid-line
    clear_rec();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 55; i++) step(1'b0, (i >= 15 && i <= 24), 1'b0);
    chk("t2_rd_in_stall", 32'(stall_rd), 32'd0);
    chk("t2_n_rd", 32'(n_rd), 32'd40);
    chk("t2_n_valid", 32'(n_v), 32'd40);
    chk("t2_line_done", 32'(ld_cyc), 32'd52);
    chk("t2_underrun", 32'(underrun_err), 32'd0);
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_line_index", 32'(line_index), 32'd2);

    // starved line: watchdog trips after 255 stall cycles; clr_err loses to a same-cycle set
    clear_rec();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 270; i++) step(1'b0, (i >= 6), (i == 260 || i == 263));
    chk("t3_n_rd", 32'(n_rd), 32'd5);
    chk("t3_n_valid", 32'(n_v), 32'd5);
    chk("t3_err_set", 32'(first_err), 32'd261);
    chk("t3_err_clear", 32'(clear_at), 32'd264);
    chk("t3_no_line_done", 32'(n_ld), 32'd0);
    chk("t3_no_frame_done", 32'(n_fd), 32'd0);
    chk("t3_last_busy", 32'(last_busy), 32'd261);
    chk("t3_line_index", 32'(line_index), 32'd2);

    // four lines from index 2: frame_done only on line 3, index wraps to 0
    for (int k = 0; k < 4; k++) begin
      clear_rec();
      step(1'b1, 1'b0, 1'b0);
      repeat (45) step(1'b0, 1'b0, 1'b0);
      chk("t4_line_done", 32'(ld_cyc), 32'd42);
      chk("t4_frame_done", 32'(n_fd), (((2 + k) % 4) == 3) ? 32'd1 : 32'd0);
      chk("t4_line_index", 32'(line_index), 32'((3 + k) % 4));
    end

    // start_line while busy and in the line_done cycle is ignored
    clear_rec();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 50; i++) step((i == 10 || i == 42), 1'b0, 1'b0);
    chk("t5_n_rd", 32'(n_rd), 32'd40);
    chk("t5_n_line_done", 32'(n_ld), 32'd1);
    chk("t5_last_busy", 32'(last_busy), 32'd42);
    chk("t5_line_index", 32'(line_index), 32'd3);

    // reset at word 20, then a clean line from index 0
    clear_rec();
    step(1'b1, 1'b0, 1'b0);
    repeat (22) step(1'b0, 1'b0, 1'b0);
    chk("t6_words_before_reset", 32'(n_v), 32'd20);
    reset_all = 1'b1;
    #1;
    chk_zero("mid_reset");
    @(negedge fpga_clk);
    reset_all = 1'b0;
    clear_rec();
    step(1'b1, 1'b0, 1'b0);
    repeat (45) step(1'b0, 1'b0, 1'b0);
    chk("t6_first_valid", 32'(first_v), 32'd3);
    chk("t6_n_valid", 32'(n_v), 32'd40);
    chk("t6_line_done", 32'(ld_cyc), 32'd42);
    chk("t6_line_index", 32'(line_index), 32'd1);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_clock_out_engine.md
LINE_CLOCK_OUT_ENGINE -- requirements
Module: line_clock_out_engine

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 40, meaning 32-bit words per display line (legal 1..255).
REQ-002 SHALL have parameter LINES_PER_FRAME, default 1280, meaning lines per frame (legal 1..2047).
REQ-003 SHALL have parameter STALL_LIMIT, default 255, meaning max consecutive FIFO-empty stall cycles within a line before abort (legal 1..255).
REQ-004 SHALL have port fpga_clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset_all  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start_line  input  1  one-cycle request to clock out one line (driven by timing controller start_clocking_frame_data_cmd).
REQ-007 SHALL have port fifo_empty  input  1  line FIFO empty flag.
REQ-008 SHALL have port fifo_rd_data  input  32  FIFO read data, valid the cycle after fifo_rd_en.
REQ-009 SHALL have port clr_err  input  1  synchronous clear of underrun_err.
REQ-010 SHALL have port fifo_rd_en  output  1  FIFO read strobe.
REQ-011 SHALL have port slm_data  output  32  registered word to SLM.
REQ-012 SHALL have port slm_data_valid  output  1  slm_data qualifier.
REQ-013 SHALL have port slm_line_start  output  1  pulse with first valid word of a line.
REQ-014 SHALL have port line_done  output  1  pulse with last valid word of a line.
REQ-015 SHALL have port frame_done  output  1  pulse with last word of last line of frame.
REQ-016 SHALL have port busy  output  1  high while not IDLE.
REQ-017 SHALL have port line_index  output  11  index of line currently/next clocked out.
REQ-018 SHALL have port underrun_err  output  1  sticky stall-timeout flag.

Function
REQ-019 SHALL implement states IDLE, READ, DRAIN.
REQ-020 SHALL, in IDLE, go to READ on start_line=1, clearing request counter, output counter and stall counter; start_line in READ/DRAIN SHALL be ignored.
REQ-021 SHALL drive fifo_rd_en = (state==READ) & ~fifo_empty & (words requested < WORDS_PER_LINE), combinationally.
REQ-022 SHALL go READ->DRAIN in the cycle the WORDS_PER_LINE-th fifo_rd_en is issued.
REQ-023 SHALL register fifo_rd_data into slm_data with slm_data_valid=1 such that fifo_rd_en in cycle N yields that word on slm_data with slm_data_valid=1 in cycle N+2 (fixed latency 2).
REQ-024 SHALL hold slm_data at its last value when slm_data_valid=0.
REQ-025 SHALL assert slm_line_start with the 1st valid word and line_done with the WORDS_PER_LINE-th valid word; both pulse together when WORDS_PER_LINE=1.
REQ-026 SHALL go DRAIN->IDLE in the cycle line_done is asserted; busy SHALL deassert the following cycle.
REQ-027 SHALL increment line_index after line_done, wrapping LINES_PER_FRAME-1 -> 0; frame_done SHALL pulse with the line_done of line LINES_PER_FRAME-1.
REQ-028 SHALL, in READ with words outstanding and fifo_empty=1, stall (fifo_rd_en=0) and increment stall counter; stall counter SHALL clear on any fifo_rd_en.
REQ-029 SHALL, when stall counter reaches STALL_LIMIT, set underrun_err, abort to IDLE after in-flight words emerge, suppress line_done/frame_done, and leave line_index unchanged.
REQ-030 SHALL clear underrun_err on clr_err=1; a same-cycle set SHALL take priority over clr_err.
REQ-031 SHALL treat start_line arriving in the cycle line_done is asserted as ignored (state not yet IDLE).

Reset
REQ-032 SHALL, on reset_all=1, immediately force state IDLE, all counters 0, line_index 0, slm_data 0, and fifo_rd_en, slm_data_valid, slm_line_start, line_done, frame_done, busy, underrun_err all 0.
REQ-033 SHALL, on reset mid-line, discard in-flight words; the first start_line after release SHALL start line 0.

Verification
REQ-034 SHALL verify: FIFO always non-empty, start_line pulse at cycle 0 -> fifo_rd_en high cycles 1..40, slm_data_valid cycles 3..42, slm_line_start at 3, line_done at 42, line_index 0->1.
REQ-035 SHALL verify: fifo_empty=1 for 10 cycles mid-line -> no rd_en during stall, 40 words still delivered in order, underrun_err=0.
REQ-036 SHALL verify: fifo_empty held 255 cycles -> underrun_err=1, no line_done, line_index unchanged, clr_err clears it.
REQ-037 SHALL verify: LINES_PER_FRAME=4, four lines -> frame_done only with 4th line_done, line_index wraps 3->0.
REQ-038 SHALL verify: start_line while busy ignored; reset_all asserted at word 20 -> all outputs 0 immediately, next line starts at line_index 0.
